// File: rtl/layer_result_streamer.sv
// layer_result_streamer
// Transmit end of the classifier result path. Captures the NN4 parallel output-layer
// neuron values in one cycle, then streams them one per cycle (index 0 first) to the
// argmax receiver. After the last element it waits for the receiver's found_max response,
// latches the predicted class, and then waits for found_max to drop before going idle.
//
// Ports:
//   clk             - single clock, rising edge
//   reset           - synchronous, active-high reset
//   layer_data      - packed neuron outputs, neuron k at [k*INDATA_WIDTH +: INDATA_WIDTH]
//   layer_valid     - one-cycle capture strobe (ignored while busy)
//   stream_ready    - receiver accepts the presented element this cycle
//   found_max       - receiver argmax complete (level, held until receiver reset)
//   predicted_in    - receiver argmax index, valid while found_max=1
//   find_max        - high from the first streamed element until response or timeout
//   valid_input     - active-low element strobe
//   input_data      - streamed element value
//   stream_index    - index of the element on input_data
//   busy            - transaction in progress
//   done            - one-cycle pulse when predicted_class is updated
//   predicted_class - latched class result
//   timeout_err     - sticky timeout flag, cleared by reset or the next accepted capture
module layer_result_streamer #(
  parameter int unsigned INDATA_WIDTH   = 47,
  parameter int unsigned NN4            = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NN4*INDATA_WIDTH-1:0]   layer_data,
  input  logic                          layer_valid,
  input  logic                          stream_ready,
  input  logic                          found_max,
  input  logic [3:0]                    predicted_in,
  output logic                          find_max,
  output logic                          valid_input,
  output logic [INDATA_WIDTH-1:0]       input_data,
  output logic [3:0]                    stream_index,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    predicted_class,
  output logic                          timeout_err
);

  localparam int unsigned IdxW  = (NN4 > 1) ? $clog2(NN4) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StStream  = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  localparam logic [3:0]       LastIdx  = 4'(NN4 - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  logic [1:0]                            state_q, state_d;
  logic [NN4-1:0][INDATA_WIDTH-1:0]      bank_q, bank_d;
  logic [WaitW-1:0]                      wait_q, wait_d;
  logic                                  find_max_q, find_max_d;
  logic                                  valid_input_q, valid_input_d;
  logic [INDATA_WIDTH-1:0]               input_data_q, input_data_d;
  // stream_index doubles as the element counter.
  logic [3:0]                            index_q, index_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic [3:0]                            class_q, class_d;
  logic                                  timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    wait_d        = wait_q;
    find_max_d    = find_max_q;
    valid_input_d = valid_input_q;
    input_data_d  = input_data_q;
    index_d       = index_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    class_d       = class_q;
    timeout_d     = timeout_q;

    case (state_q)
      StIdle: begin
        if (layer_valid) begin
          bank_d        = layer_data;
          timeout_d     = 1'b0;
          state_d       = StStream;
          busy_d        = 1'b1;
          find_max_d    = 1'b1;
          // Element 0 is presented in the first cycle after capture.
          input_data_d  = layer_data[INDATA_WIDTH-1:0];
          index_d       = 4'd0;
          valid_input_d = 1'b0;
        end
      end
      StStream: begin
        // found_max here is an early response and is deliberately ignored.
        if (stream_ready) begin
          if (index_q == LastIdx) begin
            valid_input_d = 1'b1;
            wait_d        = '0;
            state_d       = StWait;
          end else begin
            index_d      = index_q + 4'd1;
            input_data_d = bank_q[IdxW'(index_q + 4'd1)];
          end
        end
      end
      StWait: begin
        // A response in the final wait cycle beats the timeout.
        if (found_max) begin
          class_d    = predicted_in;
          done_d     = 1'b1;
          find_max_d = 1'b0;
          state_d    = StRelease;
        end else if (wait_q == WaitLast) begin
          timeout_d  = 1'b1;
          find_max_d = 1'b0;
          state_d    = StRelease;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRelease: begin
        // Receiver holds found_max until it sees find_max drop; wait for it to clear.
        if (!found_max) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bank_q        <= '0;
      wait_q        <= '0;
      find_max_q    <= 1'b0;
      valid_input_q <= 1'b1;
      input_data_q  <= '0;
      index_q       <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_q       <= 4'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      wait_q        <= wait_d;
      find_max_q    <= find_max_d;
      valid_input_q <= valid_input_d;
      input_data_q  <= input_data_d;
      index_q       <= index_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      class_q       <= class_d;
      timeout_q     <= timeout_d;
    end
  end

  assign find_max        = find_max_q;
  assign valid_input     = valid_input_q;
  assign input_data      = input_data_q;
  assign stream_index    = index_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign predicted_class = class_q;
  assign timeout_err     = timeout_q;

endmodule
